multicycle_ctrl_fsm: RTL and testbench
======================================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Main control unit of the multi-cycle processor. Sequences the shared datapath
//  (PC, IR, register file, ALU, unified memory) through FETCH/DECODE/EXEC/MEM/WB
//  on the single system clock. Drives all datapath strobes and mux selects from
//  its state and the IR opcode. Sits beside the datapath top; clk comes from clkGenerator.
// PARAMETERS
//  OPC_W    4  opcode width (IR[15:12])
//  STATE_W  3  state register width
// PORTS
//  clk        in   1  system clock; all state changes on posedge
//  rst        in   1  synchronous, active-high reset
//  opcode     in   4  IR[15:12]; stable from the cycle after FETCH
//  zero       in   1  ALU zero flag, valid in EXEC
//  mem_ready  in   1  memory done; port exists only with MEM_HANDSHAKE_EN
//  pc_write   out  1  load PC
//  pc_src     out  2  0=PC+1  1=branch target  2=jump target  3=return addr (stack reg)
//  ir_write   out  1  load IR from memory data
//  mem_read   out  1  memory read strobe
//  mem_write  out  1  memory write strobe
//  iord       out  1  0=address from PC, 1=address from ALU result
//  reg_write  out  1  register file write
//  reg_dst    out  1  0=Rd, 1=Rt
//  wb_src     out  1  0=ALU result, 1=memory data
//  alu_src_b  out  1  0=register B, 1=sign-extended immediate
//  alu_op     out  2  0=ADD 1=SUB 2=AND 3=from funct (unused, reserved)
//  ret_save   out  1  write PC+1 into return-address register (CALL)
//  illegal    out  1  sticky flag: unknown opcode decoded
//  state_dbg  out  3  current state encoding
// BEHAVIOUR
//  - Opcodes: 0 AND, 1 ADD, 2 SUB, 3 ANDI, 4 ADDI, 5 LW, 6 SW, 7 BEQ, 8 BNE,
//    9 JMP, 10 CALL, 11 RET, 12-15 illegal.
//  - States: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 HALT=7.
//  - rst high at posedge -> state=FETCH, illegal=0. All strobes are 0 during any cycle with rst=1.
//  - Outputs are Moore: combinational from state and opcode; no extra latency.
//  - FETCH: mem_read=1, iord=0, ir_write=1, pc_write=1, pc_src=0 -> DECODE.
//  - DECODE: JMP: pc_write, pc_src=2. CALL: pc_write, pc_src=2, ret_save.
//    RET: pc_write, pc_src=3. Each -> FETCH. 12-15 -> HALT, illegal<=1. Others -> EXEC.
//  - EXEC: R-type: alu_src_b=0, alu_op per opcode -> WB.
//    ANDI/ADDI/LW/SW: alu_src_b=1; ALU ops use alu_op=AND/ADD.
//    ANDI/ADDI -> WB. LW/SW -> MEM.
//    BEQ/BNE: alu_op=SUB; pc_write=zero (BEQ) or !zero (BNE), pc_src=1 -> FETCH.
//  - MEM: iord=1. LW: mem_read -> WB. SW: mem_write -> FETCH.
//  - WB: reg_write=1. reg_dst=0 for R-type, else 1. wb_src=1 only for LW -> FETCH.
//  - HALT: all strobes 0; exit only via rst.
//  - Cycles per instruction: JMP/CALL/RET 2, BEQ/BNE 3, R/I-ALU 4, SW 4, LW 5.
//  - rst mid-instruction: the instruction is abandoned; no partial strobe is issued in the rst cycle.
// CONFIGURATION
//  MEM_HANDSHAKE_EN defined:
//   - mem_ready port is present.
//   - FETCH and MEM hold their state, with mem_read/mem_write held high, until mem_ready=1.
//   - pc_write and ir_write in FETCH assert only in the cycle where mem_ready=1.
//  MEM_HANDSHAKE_EN undefined:
//   - No mem_ready port; memory is single-cycle and the CPI above applies exactly.
// STRUCTURE
//  - Package cpu_ctrl_pkg holds the opcode localparams, state encodings, and alu_op and pc_src codes.
//    The datapath imports the same package.
//  - One sub-module, ctrl_opcode_class (combinational): maps opcode to the is_rtype,
//    is_imm, is_load, is_store, is_branch, is_jump and is_illegal classes.
// TESTING
//  - Reset: hold rst 2 cycles mid-LW -> state_dbg=0, all strobes 0, illegal=0.
//  - ADD (op 1): states 0,1,2,4; reg_write=1 only in WB, reg_dst=0, wb_src=0. 4 cycles total.
//  - LW (op 5): 5 cycles; MEM has iord=1 and mem_read=1; WB has wb_src=1 and reg_dst=1.
//  - BEQ, zero=1 -> EXEC pc_write=1, pc_src=1. BNE, zero=1 -> pc_write=0. Both -> FETCH.
//  - CALL (op 10) -> DECODE: pc_src=2 and ret_save=1. Next RET (op 11) -> pc_src=3.
//  - op 13 -> HALT, illegal=1, stays 20 cycles; rst -> FETCH.
//    With MEM_HANDSHAKE_EN: mem_ready low 3 cycles in FETCH -> ir_write only on cycle 4.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle CPU control unit and datapath:
// opcode values, FSM state encodings, ALU operation and PC source codes.
package cpu_ctrl_pkg;

  localparam int CTRL_OPC_W   = 4;
  localparam int CTRL_STATE_W = 3;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_ANDI = 4'd3;
  localparam logic [3:0] OP_ADDI = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_SW   = 4'd6;
  localparam logic [3:0] OP_BEQ  = 4'd7;
  localparam logic [3:0] OP_BNE  = 4'd8;
  localparam logic [3:0] OP_JMP  = 4'd9;
  localparam logic [3:0] OP_CALL = 4'd10;
  localparam logic [3:0] OP_RET  = 4'd11;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_AND   = 2'd2;
  localparam logic [1:0] ALU_FUNCT = 2'd3;  // reserved

  localparam logic [1:0] PC_INC    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_RET    = 2'd3;

endpackage

// File: rtl/ctrl_opcode_class.sv
// Combinational opcode classifier: groups the IR opcode into the instruction
// classes the control FSM branches on.
module ctrl_opcode_class
  import cpu_ctrl_pkg::*;
#(
  parameter int OPC_W = CTRL_OPC_W
) (
  input  logic [OPC_W-1:0] opcode,
  output logic             is_rtype,
  output logic             is_imm,
  output logic             is_load,
  output logic             is_store,
  output logic             is_branch,
  output logic             is_jump,
  output logic             is_illegal
);

  // Decode opcode into one-hot-ish class flags; unknown codes are illegal
  always_comb begin
    is_rtype   = 1'b0;
    is_imm     = 1'b0;
    is_load    = 1'b0;
    is_store   = 1'b0;
    is_branch  = 1'b0;
    is_jump    = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_AND, OP_ADD, OP_SUB:   is_rtype  = 1'b1;
      OP_ANDI, OP_ADDI:         is_imm    = 1'b1;
      OP_LW:                    is_load   = 1'b1;
      OP_SW:                    is_store  = 1'b1;
      OP_BEQ, OP_BNE:           is_branch = 1'b1;
      OP_JMP, OP_CALL, OP_RET:  is_jump   = 1'b1;
      default:                  is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control unit of the multi-cycle processor. Steps the shared datapath
// through FETCH/DECODE/EXEC/MEM/WB and drives all strobes and mux selects as
// Moore outputs of the state and IR opcode.
// Optional feature macro: MEM_HANDSHAKE_EN adds the mem_ready input and makes
// FETCH and MEM wait for the memory to complete.
module multicycle_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int OPC_W   = CTRL_OPC_W,
  parameter int STATE_W = CTRL_STATE_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OPC_W-1:0]   opcode,
  input  logic               zero,
`ifdef MEM_HANDSHAKE_EN
  input  logic               mem_ready,
`endif
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               ir_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               iord,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               wb_src,
  output logic               alu_src_b,
  output logic [1:0]         alu_op,
  output logic               ret_save,
  output logic               illegal,
  output logic [STATE_W-1:0] state_dbg
);

  state_t state;
  state_t state_nxt;
  logic   mem_done;
  logic   is_rtype, is_imm, is_load, is_store, is_branch, is_jump, is_illegal;

`ifdef MEM_HANDSHAKE_EN
  assign mem_done = mem_ready;
`else
  assign mem_done = 1'b1;
`endif

  ctrl_opcode_class #(.OPC_W(OPC_W)) u_class (
    .opcode     (opcode),
    .is_rtype   (is_rtype),
    .is_imm     (is_imm),
    .is_load    (is_load),
    .is_store   (is_store),
    .is_branch  (is_branch),
    .is_jump    (is_jump),
    .is_illegal (is_illegal)
  );

  assign state_dbg = STATE_W'(state);

  // State register; reset abandons any in-flight instruction
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  // Sticky illegal-opcode flag, set when an unknown opcode is decoded
  always_ff @(posedge clk) begin
    if (rst)                                       illegal <= 1'b0;
    else if (state == S_DECODE && is_illegal)      illegal <= 1'b1;
  end

  // Next-state and Moore strobe decode; everything forced low while rst is high
  always_comb begin
    state_nxt = state;
    pc_write  = 1'b0;
    pc_src    = PC_INC;
    ir_write  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    iord      = 1'b0;
    reg_write = 1'b0;
    reg_dst   = 1'b0;
    wb_src    = 1'b0;
    alu_src_b = 1'b0;
    alu_op    = ALU_ADD;
    ret_save  = 1'b0;

    case (state)
      S_FETCH: begin
        // Read stays asserted while waiting; IR/PC load only on completion
        mem_read = 1'b1;
        iord     = 1'b0;
        if (mem_done) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          pc_src    = PC_INC;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_jump) begin
          pc_write  = 1'b1;
          pc_src    = (opcode == OP_RET) ? PC_RET : PC_JUMP;
          ret_save  = (opcode == OP_CALL);
          state_nxt = S_FETCH;
        end else if (is_illegal) begin
          state_nxt = S_HALT;
        end else begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_rtype) begin
          alu_src_b = 1'b0;
          if (opcode == OP_AND)      alu_op = ALU_AND;
          else if (opcode == OP_SUB) alu_op = ALU_SUB;
          else                       alu_op = ALU_ADD;
          state_nxt = S_WB;
        end else if (is_imm || is_load || is_store) begin
          // Loads/stores reuse the adder for base + offset
          alu_src_b = 1'b1;
          alu_op    = (opcode == OP_ANDI) ? ALU_AND : ALU_ADD;
          state_nxt = is_imm ? S_WB : S_MEM;
        end else if (is_branch) begin
          alu_op    = ALU_SUB;
          pc_src    = PC_BRANCH;
          pc_write  = (opcode == OP_BEQ) ? zero : ~zero;
          state_nxt = S_FETCH;
        end else begin
          state_nxt = S_FETCH;
        end
      end
      S_MEM: begin
        iord      = 1'b1;
        mem_read  = is_load;
        mem_write = is_store;
        if (mem_done) state_nxt = is_load ? S_WB : S_FETCH;
      end
      S_WB: begin
        reg_write = 1'b1;
        reg_dst   = ~is_rtype;
        wb_src    = is_load;
        state_nxt = S_FETCH;
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_FETCH;
      end
    endcase

    if (rst) begin
      pc_write  = 1'b0;
      pc_src    = PC_INC;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      iord      = 1'b0;
      reg_write = 1'b0;
      reg_dst   = 1'b0;
      wb_src    = 1'b0;
      alu_src_b = 1'b0;
      alu_op    = ALU_ADD;
      ret_save  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: walks each instruction class through
// its state sequence and checks state and packed strobes every cycle.
module tb_multicycle_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode;
  logic       zero;
`ifdef MEM_HANDSHAKE_EN
  logic       mem_ready;
`endif
  logic       pc_write, ir_write, mem_read, mem_write, iord;
  logic       reg_write, reg_dst, wb_src, alu_src_b, ret_save, illegal;
  logic [1:0] pc_src, alu_op;
  logic [2:0] state_dbg;
  logic [13:0] obs;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .zero      (zero),
`ifdef MEM_HANDSHAKE_EN
    .mem_ready (mem_ready),
`endif
    .pc_write  (pc_write),
    .pc_src    (pc_src),
    .ir_write  (ir_write),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .iord      (iord),
    .reg_write (reg_write),
    .reg_dst   (reg_dst),
    .wb_src    (wb_src),
    .alu_src_b (alu_src_b),
    .alu_op    (alu_op),
    .ret_save  (ret_save),
    .illegal   (illegal),
    .state_dbg (state_dbg)
  );

  assign obs = {pc_write, pc_src, ir_write, mem_read, mem_write, iord,
                reg_write, reg_dst, wb_src, alu_src_b, alu_op, ret_save};

  // Pack expected strobes in the same order as obs
  function automatic logic [13:0] v(input logic pcw, input logic [1:0] ps,
      input logic irw, input logic mr, input logic mw, input logic io,
      input logic rw, input logic rd, input logic wb, input logic asb,
      input logic [1:0] aop, input logic rs);
    return {pcw, ps, irw, mr, mw, io, rw, rd, wb, asb, aop, rs};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic cyc(input string tag, input logic [2:0] st, input logic [13:0] ev);
    chk({tag, " state"}, {29'd0, state_dbg}, {29'd0, st});
    chk({tag, " strobes"}, {18'd0, obs}, {18'd0, ev});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [13:0] FV;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    FV = v(1, 2'd0, 1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 0);
    rst = 1'b1; opcode = 4'd0; zero = 1'b0;
`ifdef MEM_HANDSHAKE_EN
    mem_ready = 1'b1;
`endif
    tick(); tick();
    cyc("reset", 3'd0, 14'd0);
    chk("reset illegal", {31'd0, illegal}, 32'd0);
    rst = 1'b0; #1;

    // ADD: 0,1,2,4 then back to FETCH
    cyc("add fetch", 3'd0, FV);
    opcode = 4'd1;
    tick(); cyc("add decode", 3'd1, 14'd0);
    tick(); cyc("add exec", 3'd2, v(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0));
    tick(); cyc("add wb", 3'd4, v(0, 2'd0, 0, 0, 0, 0, 1, 0, 0, 0, 2'd0, 0));
    tick(); cyc("add next fetch", 3'd0, FV);

    // LW: 5 cycles
    opcode = 4'd5;
    tick(); cyc("lw decode", 3'd1, 14'd0);
    tick(); cyc("lw exec", 3'd2, v(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 0));
    tick(); cyc("lw mem", 3'd3, v(0, 2'd0, 0, 1, 0, 1, 0, 0, 0, 0, 2'd0, 0));
    tick(); cyc("lw wb", 3'd4, v(0, 2'd0, 0, 0, 0, 0, 1, 1, 1, 0, 2'd0, 0));
    tick(); cyc("lw next fetch", 3'd0, FV);

    // SW: 4 cycles
    opcode = 4'd6;
    tick(); cyc("sw decode", 3'd1, 14'd0);
    tick(); cyc("sw exec", 3'd2, v(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 0));
    tick(); cyc("sw mem", 3'd3, v(0, 2'd0, 0, 0, 1, 1, 0, 0, 0, 0, 2'd0, 0));
    tick(); cyc("sw next fetch", 3'd0, FV);

    // ANDI: immediate, AND op, writes Rt
    opcode = 4'd3;
    tick(); cyc("andi decode", 3'd1, 14'd0);
    tick(); cyc("andi exec", 3'd2, v(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 0));
    tick(); cyc("andi wb", 3'd4, v(0, 2'd0, 0, 0, 0, 0, 1, 1, 0, 0, 2'd0, 0));
    tick(); cyc("andi next fetch", 3'd0, FV);

    // SUB and AND R-type ALU selects
    opcode = 4'd2;
    tick(); tick(); cyc("sub exec", 3'd2, v(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd1, 0));
    tick(); cyc("sub wb", 3'd4, v(0, 2'd0, 0, 0, 0, 0, 1, 0, 0, 0, 2'd0, 0));
    tick(); opcode = 4'd0;
    tick(); tick(); cyc("and exec", 3'd2, v(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd2, 0));
    tick(); tick(); cyc("and next fetch", 3'd0, FV);

    // Branches: 3 cycles, taken/not-taken on zero
    opcode = 4'd7; zero = 1'b1;
    tick(); tick(); cyc("beq z1 exec", 3'd2, v(1, 2'd1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd1, 0));
    tick(); cyc("beq z1 next fetch", 3'd0, FV);
    zero = 1'b0;
    tick(); tick(); cyc("beq z0 exec", 3'd2, v(0, 2'd1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd1, 0));
    tick();
    opcode = 4'd8; zero = 1'b1;
    tick(); tick(); cyc("bne z1 exec", 3'd2, v(0, 2'd1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd1, 0));
    tick(); cyc("bne z1 next fetch", 3'd0, FV);
    zero = 1'b0;
    tick(); tick(); cyc("bne z0 exec", 3'd2, v(1, 2'd1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd1, 0));
    tick();

    // Jumps: 2 cycles
    opcode = 4'd10;
    tick(); cyc("call decode", 3'd1, v(1, 2'd2, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1));
    tick(); cyc("call next fetch", 3'd0, FV);
    opcode = 4'd11;
    tick(); cyc("ret decode", 3'd1, v(1, 2'd3, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0));
    tick(); cyc("ret next fetch", 3'd0, FV);
    opcode = 4'd9;
    tick(); cyc("jmp decode", 3'd1, v(1, 2'd2, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0));
    tick(); cyc("jmp next fetch", 3'd0, FV);

    // Reset held 2 cycles while LW sits in MEM
    opcode = 4'd5;
    tick(); tick(); tick();
    chk("mid-lw in mem", {29'd0, state_dbg}, 32'd3);
    rst = 1'b1; #1;
    chk("rst cycle strobes", {18'd0, obs}, 32'd0);
    tick(); tick();
    cyc("mid-lw reset", 3'd0, 14'd0);
    chk("mid-lw reset illegal", {31'd0, illegal}, 32'd0);
    rst = 1'b0; #1;
    cyc("after reset fetch", 3'd0, FV);

    // Illegal opcode halts for good
    opcode = 4'd13;
    tick(); cyc("ill decode", 3'd1, 14'd0);
    chk("ill decode flag", {31'd0, illegal}, 32'd0);
    tick(); cyc("halt entry", 3'd7, 14'd0);
    chk("halt flag", {31'd0, illegal}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      zero = i[0];
      tick(); cyc("halt hold", 3'd7, 14'd0);
      chk("halt hold flag", {31'd0, illegal}, 32'd1);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    cyc("halt reset", 3'd0, FV);
    chk("halt reset flag", {31'd0, illegal}, 32'd0);

`ifdef MEM_HANDSHAKE_EN
    // Memory stalls FETCH for 3 cycles
    opcode = 4'd1; mem_ready = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      cyc("hs fetch wait", 3'd0, v(0, 2'd0, 0, 1, 0, 0, 0, 0, 0, 0, 2'd0, 0));
      tick();
    end
    mem_ready = 1'b1; #1;
    cyc("hs fetch done", 3'd0, FV);
    tick(); cyc("hs decode", 3'd1, 14'd0);
    // Memory stalls LW MEM for 2 cycles
    tick(); tick(); tick(); opcode = 4'd5;
    tick(); tick();
    mem_ready = 1'b0;
    tick(); cyc("hs mem wait", 3'd3, v(0, 2'd0, 0, 1, 0, 1, 0, 0, 0, 0, 2'd0, 0));
    tick(); cyc("hs mem wait2", 3'd3, v(0, 2'd0, 0, 1, 0, 1, 0, 0, 0, 0, 2'd0, 0));
    mem_ready = 1'b1;
    tick(); cyc("hs lw wb", 3'd4, v(0, 2'd0, 0, 0, 0, 0, 1, 1, 1, 0, 2'd0, 0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
